alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 38 +++
 rtl/alu_ctrl_rf.sv | 47 ++++
 rtl/alu_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// alu_ctrl_pkg : widths, op/state encodings and latency preload helper
// Rev 1.0
// ============================================================================
package alu_ctrl_pkg;
  localparam int M      = 163;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 1 << ADDR_W;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_ADD   = 2'b01,
    OP_SQADD = 2'b10,
    OP_SQSQ  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  // WAIT runs from preload down to zero, i.e. exactly the op's ALU latency.
  function automatic logic [CNT_W-1:0] lat_preload(input op_e op, input int mul_lat,
                                                   input int sqa_lat, input int ss_lat);
    int lat;
    case (op)
      OP_MUL:           lat = mul_lat;
      OP_ADD, OP_SQADD: lat = sqa_lat;
      default:          lat = ss_lat;
    endcase
    return CNT_W'(lat - 1);
  endfunction
endpackage
`default_nettype wire

// File: rtl/alu_ctrl_rf.sv
`default_nettype none
// ============================================================================
// alu_ctrl_rf : 8 x 163 register file, one write port, two combinational
//               operand reads and one registered (read-before-write) host read
// Rev 1.0
// ============================================================================
module alu_ctrl_rf
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [M-1:0]      wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [M-1:0]      ra_data,
  output logic [M-1:0]      rb_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [M-1:0]      rd_data
);
  logic [M-1:0] mem_q [NREGS];
  logic [M-1:0] mem_d [NREGS];
  logic [M-1:0] rd_data_q, rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
    // Host read samples the pre-write contents.
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];
  assign rd_data = rd_data_q;
endmodule
`default_nettype wire

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
// alu_ctrl : command FSM sequencing a GF(2^163) ALU over a small register file
// Rev 1.0
// ============================================================================
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 11,
  parameter int SQA_LAT = 1,
  parameter int SS_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [M-1:0]      ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [M-1:0]      rd_data,
  output logic              busy,
  output logic              done,
  output logic [M-1:0]      DA,
  output logic [M-1:0]      DB,
  output logic              Mul_enable,
  output logic              SQA_opt,
  input  logic [M-1:0]      BP_OUT1,
  input  logic [M-1:0]      BP_OUT2,
  input  logic [M-1:0]      SS_OUT
);
  generate
    if (MUL_LAT < 1 || MUL_LAT > 255 || SQA_LAT < 1 || SQA_LAT > 255 ||
        SS_LAT < 1 || SS_LAT > 255) begin : g_lat_check
      $error("alu_ctrl: latency parameters must lie in 1..255");
    end
  endgenerate

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [M-1:0]        da_q, da_d, db_q, db_d;
  logic                done_q, done_d;

  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [M-1:0]        rf_wdata;
  logic [M-1:0]        ra_data, rb_data;
  logic [M-1:0]        result;

  alu_ctrl_rf u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .ra_addr (ra_q),
    .rb_addr (rb_q),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    result = SS_OUT;
    case (op_q)
      OP_MUL:           result = BP_OUT1;
      OP_ADD, OP_SQADD: result = BP_OUT2;
      default:          result = SS_OUT;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    da_d     = da_q;
    db_d     = db_q;
    done_d   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;

    case (state_q)
      ST_IDLE: begin
        // A host load and an accept may share this cycle; ISSUE then sees the load.
        rf_we = ld_en;
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          ra_d    = cmd_ra;
          rb_d    = cmd_rb;
          rd_d    = cmd_rd;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        da_d    = ra_data;
        db_d    = rb_data;
        cnt_d   = lat_preload(op_q, MUL_LAT, SQA_LAT, SS_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_WB;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WB: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = result;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      da_q    <= '0;
      db_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      da_q    <= da_d;
      db_q    <= db_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign DA         = da_q;
  assign DB         = db_q;
  assign Mul_enable = (state_q == ST_ISSUE || state_q == ST_WAIT) && (op_q == OP_MUL);
  assign SQA_opt    = (state_q == ST_ISSUE || state_q == ST_WAIT) && (op_q == OP_SQADD);
endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_ctrl : vectors, held-command, abort and random commands vs. a
//               GF(2^163) register-file model with a latency-aware ALU stub
// Rev 1.0
// ============================================================================
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int MUL_LAT = 11;
  localparam int SQA_LAT = 1;
  localparam int SS_LAT  = 1;
  localparam logic [M-1:0] POLY_LOW = M'(8'hC9);   // x^7 + x^6 + x^3 + 1
  localparam logic [M-1:0] TOP_BIT  = {1'b1, {(M-1){1'b0}}};

  logic              clk = 1'b0;
  logic              rst, cmd_valid, cmd_ready, ld_en, busy, done, Mul_enable, SQA_opt;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_ra, cmd_rb, cmd_rd, ld_addr, rd_addr;
  logic [M-1:0]      ld_data, rd_data, DA, DB, BP_OUT1, BP_OUT2, SS_OUT;

  always #5 clk = ~clk;

  alu_ctrl #(.MUL_LAT(MUL_LAT), .SQA_LAT(SQA_LAT), .SS_LAT(SS_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .DA(DA), .DB(DB), .Mul_enable(Mul_enable), .SQA_opt(SQA_opt),
    .BP_OUT1(BP_OUT1), .BP_OUT2(BP_OUT2), .SS_OUT(SS_OUT)
  );

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc, sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[M-1] ? ((sh << 1) ^ POLY_LOW) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] ref_result(input logic [1:0] op, input logic [M-1:0] a,
                                              input logic [M-1:0] b);
    case (op)
      2'b00:   return gf_mul(a, b);
      2'b01:   return a ^ b;
      2'b10:   return gf_mul(a, a) ^ b;
      default: return gf_mul(gf_mul(b, b), gf_mul(b, b));
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op);
    if (op == 2'b00) return MUL_LAT;
    if (op == 2'b11) return SS_LAT;
    return SQA_LAT;
  endfunction

  function automatic logic [M-1:0] rand_word();
    logic [M-1:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = (r << 32) | M'($urandom);
    return r;
  endfunction

  // ALU stub: results appear only once the op's latency has elapsed since ISSUE.
  int   stub_cnt = 0;
  logic stub_sqa = 1'b0;
  always @(posedge clk) begin
    if (!busy) begin
      stub_cnt <= 0;
      stub_sqa <= 1'b0;
    end else begin
      if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
      if (SQA_opt) stub_sqa <= 1'b1;
    end
  end
  always_comb begin
    BP_OUT1 = (stub_cnt >= MUL_LAT) ? gf_mul(DA, DB) : '0;
    BP_OUT2 = (stub_cnt >= SQA_LAT) ? ((stub_sqa || SQA_opt) ? (gf_mul(DA, DA) ^ DB) : (DA ^ DB)) : '0;
    SS_OUT  = (stub_cnt >= SS_LAT) ? gf_mul(gf_mul(DB, DB), gf_mul(DB, DB)) : '0;
  end

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [M-1:0] ref_rf [NREGS];

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_reg(input logic [2:0] a, input logic [M-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    ref_rf[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_reg(input logic [2:0] a, input logic [M-1:0] exp, input string name);
    rd_addr = a;
    @(negedge clk);
    chk(name, rd_data, exp);
    chk("done_single_pulse", M'(done), '0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic issue_cmd(input logic [1:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rd, input bit co_ld, input logic [2:0] co_addr,
                           input logic [M-1:0] co_data, input bit keep_valid, input bit ld_wait);
    int lat, cyc, me_cnt, sq_cnt, rdy_bad;
    logic [M-1:0] a, b, res, old;
    chk("cmd_ready_idle", M'(cmd_ready), M'(1'b1));
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
    if (co_ld) begin
      ld_en = 1'b1; ld_addr = co_addr; ld_data = co_data;
      ref_rf[co_addr] = co_data;
    end
    a   = ref_rf[ra];
    b   = ref_rf[rb];
    old = ref_rf[rd];
    res = ref_result(op, a, b);
    lat = ref_lat(op);
    @(negedge clk);
    ld_en = 1'b0;
    if (!keep_valid) cmd_valid = 1'b0;
    cyc = 0; me_cnt = 0; sq_cnt = 0; rdy_bad = 0;
    while (!done && cyc < lat + 20) begin
      if (Mul_enable) me_cnt++;
      if (SQA_opt) sq_cnt++;
      if (cmd_ready) rdy_bad++;
      if (cyc == 1) begin
        chk("DA_operand", DA, a);
        chk("DB_operand", DB, b);
      end
      if (ld_wait && cyc == 1) begin
        ld_en = 1'b1; ld_addr = 3'd5; ld_data = M'(7);
      end else begin
        ld_en = 1'b0;
      end
      if (cyc == lat + 1) rd_addr = rd;
      @(negedge clk);
      cyc++;
    end
    ld_en = 1'b0;
    chk_int("done_latency", cyc, lat + 2);
    chk_int("mul_enable_cycles", me_cnt, (op == 2'b00) ? lat + 1 : 0);
    chk_int("sqa_opt_cycles", sq_cnt, (op == 2'b10) ? lat + 1 : 0);
    chk_int("cmd_ready_low_busy", rdy_bad, 0);
    chk("rd_before_write", rd_data, old);
    ref_rf[rd] = res;
  endtask

  typedef struct {
    logic [2:0]   la;
    logic [M-1:0] da;
    logic [2:0]   lb;
    logic [M-1:0] db;
    logic [1:0]   op;
    logic [2:0]   ra, rb, rd;
    logic [M-1:0] exp;
  } vec_t;

  vec_t         tbl [6];
  int           done_seen;
  logic [2:0]   r_ra, r_rb, r_rd, r_co_addr;
  logic [1:0]   r_op;
  bit           r_co;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < NREGS; i++) ref_rf[i] = '0;

    tbl[0] = '{la: 3'd1, da: M'(3), lb: 3'd2, db: M'(5), op: 2'b01, ra: 3'd1, rb: 3'd2, rd: 3'd3, exp: M'(6)};
    tbl[1] = '{la: 3'd1, da: M'(2), lb: 3'd2, db: M'(3), op: 2'b00, ra: 3'd1, rb: 3'd2, rd: 3'd4, exp: M'(6)};
    tbl[2] = '{la: 3'd2, da: M'(2), lb: 3'd2, db: M'(2), op: 2'b11, ra: 3'd0, rb: 3'd2, rd: 3'd2, exp: M'(16)};
    tbl[3] = '{la: 3'd1, da: M'(3), lb: 3'd2, db: M'(1), op: 2'b10, ra: 3'd1, rb: 3'd2, rd: 3'd6, exp: M'(4)};
    tbl[4] = '{la: 3'd1, da: TOP_BIT, lb: 3'd2, db: M'(2), op: 2'b00, ra: 3'd1, rb: 3'd2, rd: 3'd7, exp: M'(8'hC9)};
    tbl[5] = '{la: 3'd7, da: M'(8'hAB), lb: 3'd7, db: M'(8'hAB), op: 2'b01, ra: 3'd7, rb: 3'd7, rd: 3'd7, exp: '0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", M'(cmd_ready), M'(1'b1));
    chk("reset_busy", M'(busy), '0);
    chk("reset_done", M'(done), '0);
    chk("reset_mul_enable", M'(Mul_enable), '0);
    chk("reset_sqa_opt", M'(SQA_opt), '0);
    chk("reset_DA", DA, '0);
    chk("reset_DB", DB, '0);
    chk("reset_rd_data", rd_data, '0);

    for (int i = 0; i < 6; i++) begin
      load_reg(tbl[i].la, tbl[i].da);
      load_reg(tbl[i].lb, tbl[i].db);
      issue_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rd, 1'b0, 3'd0, '0, 1'b0, 1'b0);
      check_reg(tbl[i].rd, tbl[i].exp, $sformatf("vec%0d_result", i));
    end

    // Requester holds cmd_valid across a MUL and pokes ld_en mid-WAIT.
    load_reg(3'd5, M'(9));
    load_reg(3'd1, M'(8'h35));
    load_reg(3'd2, M'(8'h1F));
    issue_cmd(2'b00, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, '0, 1'b1, 1'b1);
    issue_cmd(2'b00, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    check_reg(3'd3, ref_rf[3], "held_cmd_result");
    check_reg(3'd5, M'(9), "r5_ld_in_wait_ignored");

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        load_reg(3'($urandom_range(0, 7)), rand_word());
      r_op      = 2'($urandom_range(0, 3));
      r_ra      = 3'($urandom_range(0, 7));
      r_rb      = 3'($urandom_range(0, 7));
      r_rd      = 3'($urandom_range(0, 7));
      r_co      = ($urandom_range(0, 3) == 0);
      r_co_addr = 3'($urandom_range(0, 7));
      issue_cmd(r_op, r_ra, r_rb, r_rd, r_co, r_co_addr, rand_word(), 1'b0, 1'b0);
      check_reg(r_rd, ref_rf[r_rd], $sformatf("rand%0d_result", n));
    end

    // Abort a MUL in WAIT: no write-back, no done, everything cleared.
    load_reg(3'd1, M'(2));
    load_reg(3'd2, M'(3));
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_rd = 3'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_in_wait", M'(busy), M'(1'b1));
    rst = 1'b1;
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready_after_release", M'(cmd_ready), M'(1'b1));
    chk("abort_busy", M'(busy), '0);
    chk("abort_mul_enable", M'(Mul_enable), '0);
    chk("abort_DA", DA, '0);
    chk("abort_DB", DB, '0);
    for (int i = 0; i < NREGS; i++) ref_rf[i] = '0;
    for (int i = 0; i < NREGS; i++) check_reg(3'(i), '0, $sformatf("abort_reg%0d", i));
    repeat (MUL_LAT + 4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk_int("abort_no_done", done_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
